// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: D = A - B, one 4-bit slice per clock, LSB slice first.
// Optional signed-overflow flag when SUB_OVERFLOW_EN is defined.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
`ifdef SUB_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             Borrow_out
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             bor_q, bor_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       a_sl, b_sl;
    logic [4:0]       sum;
    logic [WIDTH-1:0] merged;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            d_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            bor_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            d_q     <= d_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            bor_q   <= bor_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        d_d     = d_q;
        k_d     = k_q;
        carry_d = carry_q;
        bor_d   = bor_q;
        ovf_d   = ovf_q;
        a_sl    = a_q[4*k_q +: 4];
        b_sl    = b_q[4*k_q +: 4];
        // A + ~B + carry, carry seeded with 1 for two's complement
        sum     = {1'b0, a_sl} + {1'b0, ~b_sl} + {4'b0, carry_q};
        merged  = part_q;
        merged[4*k_q +: 4] = sum[3:0];
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = 1'b1;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                part_d  = merged;
                carry_d = sum[4];
                if (k_q == KLAST) begin
                    state_d = FIN;
                    d_d     = merged;
                    bor_d   = ~sum[4];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                            && (merged[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Busy       = (state_q == RUN);
    assign Done       = (state_q == FIN);
    assign D          = d_q;
    assign Borrow_out = bor_q;

`ifdef SUB_OVERFLOW_EN
    assign Overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
